hilo_muldiv_unit: RTL

Parametrised, iterative multiply/divide unit that owns the HI/LO register pair for the pipelined MIPS datapath. It executes mult, multu, madd, msub, div, divu, mthi and mtlo as a multi-cycle operation beside the single-cycle EX ALU, with a start/busy/done handshake. HI/LO are exposed combinationally for mfhi/mflo forwarding, and a hazard output stalls the pipeline while a result is pending.

---
 rtl/hilo_muldiv_unit.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit owning the HI/LO register pair. Runs
//   mult, multu, madd, msub, div, divu in the background of the EX stage
//   with a start/busy/done handshake. mthi/mtlo complete in a single edge.
//
//   Ports:
//     Clk, Rst_n          clock, asynchronous active-low reset
//     Start, Op, A, B     request, opcode and rs/rt operands
//     Cancel              flush of the in-flight op (wins over Start)
//     HiRead              ID stage needs HI/LO this cycle
//     HI, LO              architectural HI/LO registers
//     Busy                iterative op in flight
//     Done, DivZero       one-cycle completion pulse, divide-by-zero flag
//     Stall               Busy & (Start | HiRead)
//
//   state | meaning
//   IDLE  | waiting for Start; mthi/mtlo are handled here
//   CALC  | WIDTH shift steps, then one sign-correction cycle
//   FIN   | accumulate (madd/msub) and write HI/LO, pulse Done
module hilo_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cancel,
  input  logic             HiRead,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic             Stall
);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIN} state_t;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  state_t                 state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend / quotient bits}.
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       opb_q, opb_d;
  logic [2:0]             op_q, op_d;
  logic                   neg_q, neg_d;
  logic                   rneg_q, rneg_d;
  logic                   dz_q, dz_d;
  logic [WIDTH-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       lo_q, lo_d;
  logic                   done_q, done_d;
  logic                   divzero_q, divzero_d;

  logic                   signed_in;
  logic                   a_neg, b_neg;
  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         mul_sum;
  logic [2*WIDTH-1:0]     mul_next;
  logic [WIDTH:0]         div_shift;
  logic [WIDTH+1:0]       div_diff;
  logic [2*WIDTH-1:0]     div_next;
  logic [WIDTH-1:0]       quot, rem;
  logic [2*WIDTH-1:0]     mul_fix, div_fix;
  logic [2*WIDTH-1:0]     hilo_cur;

  always_comb begin
    signed_in = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
    a_neg     = signed_in & A[WIDTH-1];
    b_neg     = signed_in & B[WIDTH-1];
    a_mag     = a_neg ? (~A + WIDTH'(1)) : A;
    b_mag     = b_neg ? (~B + WIDTH'(1)) : B;

    // Radix-2 shift-add: add multiplicand to the upper half when the
    // current multiplier LSB is set, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring division: remainder and dividend shift left together; the
    // quotient bit enters at the bottom as dividend bits leave the top.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_next  = div_diff[WIDTH+1] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
    mul_fix   = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    // With B=0 the restoring loop leaves |A| as remainder, so restoring the
    // dividend sign reproduces the original A in HI; LO is forced to ones.
    div_fix   = {rneg_q ? (~rem + WIDTH'(1)) : rem,
                 dz_q ? {WIDTH{1'b1}} : (neg_q ? (~quot + WIDTH'(1)) : quot)};
    hilo_cur  = {hi_q, lo_q};
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (Start && !Cancel) begin
          if (Op == OP_MTHI) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (Op == OP_MTLO) begin
            lo_d   = A;
            done_d = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = '0;
            op_d    = Op;
            acc_d   = {{WIDTH{1'b0}}, a_mag};
            opb_d   = b_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            dz_d    = (B == '0);
          end
        end
      end

      ST_CALC: begin
        if (Cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q != CNTW'(WIDTH)) begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNTW'(1);
        end else begin
          // Sign correction gets its own cycle so the negate and the
          // madd/msub 2*WIDTH add never sit in the same path.
          acc_d   = op_q[2] ? div_fix : mul_fix;
          state_d = ST_FIN;
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
        if (!Cancel) begin
          case (op_q)
            OP_MADD: {hi_d, lo_d} = hilo_cur + acc_q;
            OP_MSUB: {hi_d, lo_d} = hilo_cur - acc_q;
            default: {hi_d, lo_d} = acc_q;
          endcase
          done_d    = 1'b1;
          divzero_d = op_q[2] & dz_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign HI      = hi_q;
  assign LO      = lo_q;
  assign Busy    = (state_q != ST_IDLE);
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Stall   = Busy & (Start | HiRead);

endmodule
